rice_residual_encoder: RTL and testbench
========================================

Name: rice_residual_encoder

Overview:
Pipelined stage directly upstream of the Rice bit-packer. It accepts one signed 16-bit LPC residual per cycle and zigzag-maps it to unsigned. It splits the mapped value into a unary quotient and a binary remainder using the partition's Rice parameter, and emits the (total, upper, lower, param) tuple that the packer consumes. It also tracks partition boundaries so the packer knows when to emit a parameter header.

Parameters:
PART_SIZE, 4096, samples per Rice partition (power of two, 2..65536)
MAX_UPPER, 16'd4095, quotient above which oEscape is flagged

Ports:
iClock  in  1  clock
iReset  in  1  reset
iValid  in  1  residual valid this cycle
iStart  in  1  start of new block; restarts the partition count
iResidual  in  16  signed two's-complement residual
iRiceParam  in  4  Rice parameter k (0..15); sampled only at partition start
oValid  out  1  output tuple valid; drives the packer enable
oFirst  out  1  tuple is the first sample of a partition (packer inserts header)
oLast  out  1  tuple is the last sample of a partition
oTotal  out  16  upper + k + 1
oUpper  out  16  unary quotient length
oLower  out  16  1 concatenated with the k low bits of the mapped value
oRiceParam  out  4  k in effect for this tuple
oEscape  out  1  quotient exceeded MAX_UPPER

Behaviour:
- Reset is iReset, synchronous, active-high; clock is iClock. On reset, all outputs are 0.
- On reset, the partition counter is 0, the armed flag is 1 (the next valid sample is the first of a partition), and the latched k is 0.
- Pipeline has 2 stages with no backpressure. The output tuple appears exactly 2 cycles after the input cycle with iValid=1. oValid follows iValid delayed by 2 cycles.
- Stage 1 (zigzag):
  - u = (r << 1) XOR (r >>> 15), computed in 16 bits. Range 0..65535, no overflow.
  - Stage 1 registers u, the effective k, the first flag and the last flag.
- Effective k: iRiceParam if the sample is the first of a partition, otherwise the latched k. The latched k updates only on first samples, so mid-partition changes to iRiceParam are ignored.
- Stage 2 (split):
  - upper = u >> k.
  - lower = (1 << k) | (u & ((1 << k) - 1)). Always fits 16 bits, including k=15.
  - total = upper + k + 1, truncated to 16 bits. It wraps only when k=0 and u=65535; oEscape also covers this case.
  - oEscape = (upper > MAX_UPPER). The tuple is still emitted unchanged; escape handling belongs to the parameter-search logic.
- Partition counter:
  - Increments on each accepted sample.
  - On the sample where count == PART_SIZE-1, that sample carries last=1, the counter wraps to 0 and the armed flag is set.
  - A sample accepted while armed carries first=1, and the armed flag is cleared.
- iStart handling:
  - iStart alone: counter cleared, armed set; the next valid sample is first.
  - iStart and iValid in the same cycle: the current sample is first and the counter becomes 1 (0 if PART_SIZE=1 is ever allowed; it is excluded by the parameter range).
  - iStart mid-partition: the partial partition is abandoned. No oLast is emitted for it. Samples already in the pipeline drain unchanged.
- Cycles with iValid=0 do not advance the counter and do not disturb the pipeline contents (bubbles propagate with oValid=0). Output data fields are don't-care when oValid=0, but are held at their last values to reduce toggling.
- Reset mid-operation: in-flight samples are discarded and oValid is 0 from the next edge onward.

Decomposition:
- Package rice_pkg holds:
  - constants RES_W=16 and RICE_PARAM_W=4;
  - function zigzag16;
  - a packed struct rice_code_t {total, upper, lower, param}, shared with the packer.
- One natural sub-module: rice_partition_counter. It holds the counter, armed flag and latched k, and outputs first/last/k_eff.

Test Plan:
- k=2, r=5 -> 2 cycles later: oValid=1, oUpper=2, oLower=6 (3'b110), oTotal=5.
- k=0, r=-3 -> u=5, oUpper=5, oLower=1, oTotal=6, oEscape=0.
- k=15, r=-32768 -> u=65535, oUpper=1, oLower=16'hFFFF, oTotal=17; then k=0, r=-32768 -> oUpper=65535, oEscape=1.
- PART_SIZE=4, 9 consecutive samples, iRiceParam changed every cycle -> oFirst on samples 0, 4 and 8; oLast on samples 3 and 7; oRiceParam constant within each partition and equal to iRiceParam sampled at samples 0, 4 and 8.
- Valid-with-gaps pattern 1,0,0,1,1 with iStart asserted together with sample 4 -> outputs keep gaps; sample 4 carries oFirst=1; the counter restarts.
- iReset asserted while 2 samples are in flight -> oValid=0 on the following 2 cycles; the first sample after reset carries oFirst=1.

Source files
------------

// File: rtl/rice_pkg.sv
// Shared types and helpers for the Rice residual coding path.
package rice_pkg;

   localparam int unsigned RES_W        = 16;
   localparam int unsigned RICE_PARAM_W = 4;

   // Tuple handed to the Rice bit-packer.
   typedef struct packed {
      logic [RES_W-1:0]        total;
      logic [RES_W-1:0]        upper;
      logic [RES_W-1:0]        lower;
      logic [RICE_PARAM_W-1:0] param;
   } rice_code_t;

   // Signed-to-unsigned interleave: 0,-1,1,-2,2 -> 0,1,2,3,4.
   function automatic logic [RES_W-1:0] zigzag16(input logic [RES_W-1:0] r);
      return {r[RES_W-2:0], 1'b0} ^ {RES_W{r[RES_W-1]}};
   endfunction

endpackage

// File: rtl/rice_partition_counter.sv
// Tracks position within a Rice partition and the k latched at its first sample.
module rice_partition_counter
   import rice_pkg::*;
#(
   parameter int unsigned PART_SIZE = 4096
) (
   input  logic                    iClock,
   input  logic                    iReset,
   input  logic                    iValid,
   input  logic                    iStart,
   input  logic [RICE_PARAM_W-1:0] iRiceParam,
   output logic                    oFirst,
   output logic                    oLast,
   output logic [RICE_PARAM_W-1:0] oRiceParam
);

   localparam int unsigned CntW = (PART_SIZE > 1) ? $clog2(PART_SIZE) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(PART_SIZE - 1);

   logic [CntW-1:0]         cnt_q, cnt_d, cnt_base;
   logic                    armed_q, armed_d, armed_eff;
   logic [RICE_PARAM_W-1:0] k_q, k_d;

   // Current-sample flags; iStart takes effect on a sample in the same cycle.
   always_comb begin
      armed_eff  = iStart | armed_q;
      cnt_base   = iStart ? '0 : cnt_q;
      oFirst     = iValid & armed_eff;
      oLast      = iValid & (cnt_base == CntLast);
      oRiceParam = armed_eff ? iRiceParam : k_q;
   end

   // Next-state: advance only on accepted samples, rearm at the partition wrap.
   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      k_d     = k_q;
      if (iValid) begin
         if (oFirst) begin
            k_d = iRiceParam;
         end
         if (oLast) begin
            cnt_d   = '0;
            armed_d = 1'b1;
         end else begin
            cnt_d   = cnt_base + 1'b1;
            armed_d = 1'b0;
         end
      end else if (iStart) begin
         cnt_d   = '0;
         armed_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         cnt_q   <= '0;
         armed_q <= 1'b1;
         k_q     <= '0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         k_q     <= k_d;
      end
   end

endmodule

// File: rtl/rice_residual_encoder.sv
// Two-stage residual encoder: zigzag map, then Rice split into packer tuples.
module rice_residual_encoder
   import rice_pkg::*;
#(
   parameter int unsigned      PART_SIZE = 4096,
   parameter logic [RES_W-1:0] MAX_UPPER = 16'd4095
) (
   input  logic                    iClock,
   input  logic                    iReset,
   input  logic                    iValid,
   input  logic                    iStart,
   input  logic [RES_W-1:0]        iResidual,
   input  logic [RICE_PARAM_W-1:0] iRiceParam,
   output logic                    oValid,
   output logic                    oFirst,
   output logic                    oLast,
   output logic [RES_W-1:0]        oTotal,
   output logic [RES_W-1:0]        oUpper,
   output logic [RES_W-1:0]        oLower,
   output logic [RICE_PARAM_W-1:0] oRiceParam,
   output logic                    oEscape
);

   logic                    part_first, part_last;
   logic [RICE_PARAM_W-1:0] part_k;

   rice_partition_counter #(
      .PART_SIZE (PART_SIZE)
   ) u_part (
      .iClock     (iClock),
      .iReset     (iReset),
      .iValid     (iValid),
      .iStart     (iStart),
      .iRiceParam (iRiceParam),
      .oFirst     (part_first),
      .oLast      (part_last),
      .oRiceParam (part_k)
   );

   logic                    s1_valid_q, s1_valid_d;
   logic [RES_W-1:0]        s1_u_q, s1_u_d;
   logic [RICE_PARAM_W-1:0] s1_k_q, s1_k_d;
   logic                    s1_first_q, s1_first_d;
   logic                    s1_last_q, s1_last_d;

   logic                    s2_valid_q, s2_valid_d;
   rice_code_t              s2_code_q, s2_code_d;
   logic                    s2_first_q, s2_first_d;
   logic                    s2_last_q, s2_last_d;
   logic                    s2_escape_q, s2_escape_d;

   logic [RES_W-1:0]        split_mask;

   // Stage 1: zigzag map; data fields hold across bubbles.
   always_comb begin
      s1_valid_d = iValid;
      s1_u_d     = s1_u_q;
      s1_k_d     = s1_k_q;
      s1_first_d = s1_first_q;
      s1_last_d  = s1_last_q;
      if (iValid) begin
         s1_u_d     = zigzag16(iResidual);
         s1_k_d     = part_k;
         s1_first_d = part_first;
         s1_last_d  = part_last;
      end
   end

   // Stage 2: split into unary quotient and 1-prefixed remainder.
   always_comb begin
      s2_valid_d  = s1_valid_q;
      s2_code_d   = s2_code_q;
      s2_first_d  = s2_first_q;
      s2_last_d   = s2_last_q;
      s2_escape_d = s2_escape_q;
      split_mask  = RES_W'((17'd1 << s1_k_q) - 17'd1);
      if (s1_valid_q) begin
         s2_code_d.upper = s1_u_q >> s1_k_q;
         s2_code_d.lower = RES_W'(17'd1 << s1_k_q) | (s1_u_q & split_mask);
         s2_code_d.total = s2_code_d.upper + RES_W'(s1_k_q) + 16'd1;
         s2_code_d.param = s1_k_q;
         s2_first_d      = s1_first_q;
         s2_last_d       = s1_last_q;
         s2_escape_d     = s2_code_d.upper > MAX_UPPER;
      end
   end

   // Pipeline registers; reset drops anything in flight.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         s1_valid_q  <= 1'b0;
         s1_u_q      <= '0;
         s1_k_q      <= '0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_code_q   <= '0;
         s2_first_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_escape_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_u_q      <= s1_u_d;
         s1_k_q      <= s1_k_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         s2_valid_q  <= s2_valid_d;
         s2_code_q   <= s2_code_d;
         s2_first_q  <= s2_first_d;
         s2_last_q   <= s2_last_d;
         s2_escape_q <= s2_escape_d;
      end
   end

   // Output mapping.
   always_comb begin
      oValid     = s2_valid_q;
      oFirst     = s2_first_q;
      oLast      = s2_last_q;
      oTotal     = s2_code_q.total;
      oUpper     = s2_code_q.upper;
      oLower     = s2_code_q.lower;
      oRiceParam = s2_code_q.param;
      oEscape    = s2_escape_q;
   end

endmodule

// File: tb/tb_rice_residual_encoder.sv
// Scoreboard bench for rice_residual_encoder with a small partition size.
module tb_rice_residual_encoder;

   localparam int unsigned PartSize = 4;

   logic        iClock = 1'b0;
   logic        iReset;
   logic        iValid;
   logic        iStart;
   logic [15:0] iResidual;
   logic [3:0]  iRiceParam;
   logic        oValid, oFirst, oLast, oEscape;
   logic [15:0] oTotal, oUpper, oLower;
   logic [3:0]  oRiceParam;

   rice_residual_encoder #(
      .PART_SIZE (PartSize),
      .MAX_UPPER (16'd4095)
   ) dut (
      .iClock     (iClock),
      .iReset     (iReset),
      .iValid     (iValid),
      .iStart     (iStart),
      .iResidual  (iResidual),
      .iRiceParam (iRiceParam),
      .oValid     (oValid),
      .oFirst     (oFirst),
      .oLast      (oLast),
      .oTotal     (oTotal),
      .oUpper     (oUpper),
      .oLower     (oLower),
      .oRiceParam (oRiceParam),
      .oEscape    (oEscape)
   );

   always #5 iClock = ~iClock;

   int unsigned cyc = 0;
   always @(posedge iClock) cyc <= cyc + 1;

   typedef struct {
      int unsigned due;
      logic        first;
      logic        last;
      logic [15:0] total;
      logic [15:0] upper;
      logic [15:0] lower;
      logic [3:0]  param;
      logic        esc;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference state: position of the next sample in its partition and its k.
   int unsigned m_pos = 0;
   logic [3:0]  m_k = 4'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic s, input int r, input int k);
      exp_t e;
      int   u, pw;
      @(posedge iClock);
      #1;
      iReset     = 1'b0;
      iValid     = v;
      iStart     = s;
      iResidual  = 16'(r);
      iRiceParam = 4'(k);
      if (s) m_pos = 0;
      if (v) begin
         if (m_pos == 0) m_k = 4'(k);
         r       = int'($signed(16'(r)));
         u       = (r >= 0) ? 2 * r : -2 * r - 1;
         pw      = 1 << m_k;
         e.due   = cyc + 2;
         e.first = (m_pos == 0);
         e.last  = (m_pos == PartSize - 1);
         e.upper = 16'(u / pw);
         e.lower = 16'(pw + u % pw);
         e.total = 16'((u / pw + int'(m_k) + 1) % 65536);
         e.param = m_k;
         e.esc   = (u / pw) > 4095;
         m_pos   = (m_pos + 1) % PartSize;
         expq.push_back(e);
      end
   endtask

   task automatic do_reset(input int n);
      exp_t keep[$];
      @(posedge iClock);
      #1;
      iReset = 1'b1;
      iValid = 1'b0;
      iStart = 1'b0;
      // Outputs due this cycle are already registered; later ones are discarded.
      foreach (expq[i]) if (expq[i].due <= cyc) keep.push_back(expq[i]);
      expq  = keep;
      m_pos = 0;
      m_k   = 4'd0;
      repeat (n - 1) begin
         @(posedge iClock);
         #1;
      end
   endtask

   // Monitor: pops and compares whenever the DUT presents a tuple.
   always @(negedge iClock) begin
      if (oValid === 1'b1) begin
         if (expq.size() == 0) begin
            check("unexpected_oValid", 32'(oValid), 32'd0);
         end else begin
            mon_e = expq.pop_front();
            check("latency_cycle", cyc, mon_e.due);
            check("oFirst", 32'(oFirst), 32'(mon_e.first));
            check("oLast", 32'(oLast), 32'(mon_e.last));
            check("oUpper", 32'(oUpper), 32'(mon_e.upper));
            check("oLower", 32'(oLower), 32'(mon_e.lower));
            check("oTotal", 32'(oTotal), 32'(mon_e.total));
            check("oRiceParam", 32'(oRiceParam), 32'(mon_e.param));
            check("oEscape", 32'(oEscape), 32'(mon_e.esc));
         end
      end else if (expq.size() > 0 && expq[0].due <= cyc) begin
         check("missing_oValid", 32'(oValid), 32'd1);
         void'(expq.pop_front());
      end
   end

   initial begin
      iReset     = 1'b1;
      iValid     = 1'b0;
      iStart     = 1'b0;
      iResidual  = '0;
      iRiceParam = '0;
      repeat (2) @(posedge iClock);
      @(negedge iClock);
      check("rst_oValid", 32'(oValid), 32'd0);
      check("rst_oFirst", 32'(oFirst), 32'd0);
      check("rst_oLast", 32'(oLast), 32'd0);
      check("rst_oTotal", 32'(oTotal), 32'd0);
      check("rst_oUpper", 32'(oUpper), 32'd0);
      check("rst_oLower", 32'(oLower), 32'd0);
      check("rst_oRiceParam", 32'(oRiceParam), 32'd0);
      check("rst_oEscape", 32'(oEscape), 32'd0);

      // Directed arithmetic cases, each opening a fresh partition.
      drive(1, 1, 5, 2);
      drive(1, 1, -3, 0);
      drive(1, 1, -32768, 15);
      drive(1, 1, -32768, 0);
      drive(1, 1, 32767, 0);
      drive(0, 0, 0, 0);

      // Partition boundaries with k changing every cycle.
      drive(1, 1, 100, 0);
      for (int i = 1; i < 9; i++) drive(1, 0, i * 37 - 150, i);
      drive(0, 0, 0, 0);

      // Gaps, with a restart on the fifth cycle.
      drive(1, 0, 11, 5);
      drive(0, 0, 0, 6);
      drive(0, 0, 0, 7);
      drive(1, 0, -2, 8);
      drive(1, 1, 9, 3);
      drive(1, 0, 40, 9);

      // Reset with samples in flight.
      drive(1, 0, 100, 3);
      drive(1, 0, -7, 3);
      do_reset(1);
      @(negedge iClock);
      @(negedge iClock);
      check("post_rst_oValid_0", 32'(oValid), 32'd0);
      @(negedge iClock);
      check("post_rst_oValid_1", 32'(oValid), 32'd0);
      drive(1, 0, 21, 4);
      drive(1, 0, 22, 9);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         int r;
         r = int'($urandom_range(0, 65535));
         if ($urandom_range(0, 9) == 0) r = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
         if ($urandom_range(0, 199) == 0) begin
            do_reset(int'($urandom_range(1, 2)));
         end else begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, r,
                  int'($urandom_range(0, 15)));
         end
      end

      drive(0, 0, 0, 0);
      for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge iClock);
      @(negedge iClock);
      check("drain_queue_empty", 32'(expq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
